// File: rtl/axil_arb2.sv
// Two-master to one-slave AXI4-Lite arbiter: one whole transaction at a time,
// round-robin between masters, write served before read when both are pending.
module axil_arb2 #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  // master 0
  input  logic                  m0_awvalid,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  input  logic [2:0]            m0_awprot,
  output logic                  m0_awready,
  input  logic                  m0_wvalid,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  output logic [1:0]            m0_bresp,
  input  logic                  m0_bready,
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [2:0]            m0_arprot,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m0_rready,
  // master 1
  input  logic                  m1_awvalid,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  input  logic [2:0]            m1_awprot,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [2:0]            m1_arprot,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic [1:0]            m1_rresp,
  input  logic                  m1_rready,
  // shared slave port
  output logic                  s_awvalid,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic [2:0]            s_awprot,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready,
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [2:0]            s_arprot,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [31:0]           s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_rready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state;
  logic   g, p;
  logic   aw_done, w_done, ar_done;

  logic   req0, req1, gnt, gnt_aw;
  logic   sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic   in_wr, in_rd, b_fwd;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req0 = m0_awvalid | m0_arvalid;
  assign req1 = m1_awvalid | m1_arvalid;

  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) gnt = p;
    else if (req1)    gnt = 1'b1;
    gnt_aw = gnt ? m1_awvalid : m0_awvalid;
  end

  always_comb begin
    sel_awvalid = g ? m1_awvalid : m0_awvalid;
    sel_wvalid  = g ? m1_wvalid  : m0_wvalid;
    sel_bready  = g ? m1_bready  : m0_bready;
    sel_arvalid = g ? m1_arvalid : m0_arvalid;
    sel_rready  = g ? m1_rready  : m0_rready;
  end

  assign in_wr = (state == WRITE);
  assign in_rd = (state == READ);
  // B is only forwarded once both AW and W have been handed to the slave
  assign b_fwd = in_wr & aw_done & w_done;

  // slave side: payload always follows g, valids/readies gated by state
  assign s_awaddr  = g ? m1_awaddr : m0_awaddr;
  assign s_awprot  = g ? m1_awprot : m0_awprot;
  assign s_wdata   = g ? m1_wdata  : m0_wdata;
  assign s_wstrb   = g ? m1_wstrb  : m0_wstrb;
  assign s_araddr  = g ? m1_araddr : m0_araddr;
  assign s_arprot  = g ? m1_arprot : m0_arprot;
  assign s_awvalid = in_wr & sel_awvalid & ~aw_done;
  assign s_wvalid  = in_wr & sel_wvalid & ~w_done;
  assign s_bready  = b_fwd & sel_bready;
  assign s_arvalid = in_rd & sel_arvalid & ~ar_done;
  assign s_rready  = in_rd & sel_rready;

  // master side
  assign m0_awready = in_wr & ~g & s_awready & ~aw_done;
  assign m0_wready  = in_wr & ~g & s_wready & ~w_done;
  assign m0_bvalid  = b_fwd & ~g & s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m0_arready = in_rd & ~g & s_arready & ~ar_done;
  assign m0_rvalid  = in_rd & ~g & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;

  assign m1_awready = in_wr & g & s_awready & ~aw_done;
  assign m1_wready  = in_wr & g & s_wready & ~w_done;
  assign m1_bvalid  = b_fwd & g & s_bvalid;
  assign m1_bresp   = s_bresp;
  assign m1_arready = in_rd & g & s_arready & ~ar_done;
  assign m1_rvalid  = in_rd & g & s_rvalid;
  assign m1_rdata   = s_rdata;
  assign m1_rresp   = s_rresp;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bready & s_bvalid;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rready & s_rvalid;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      g       <= 1'b0;
      p       <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            g     <= gnt;
            p     <= ~gnt;
            state <= gnt_aw ? WRITE : READ;
          end
        end
        WRITE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if (b_hs) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        READ: begin
          if (ar_hs) ar_done <= 1'b1;
          if (r_hs) begin
            state   <= IDLE;
            ar_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arb2.sv
// Directed bench for axil_arb2: bench plays both masters and the slave,
// checking forwarded signals against hand-computed values.
module tb_axil_arb2;

  logic        aclk = 1'b0;
  logic        areset_n;

  logic        m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready;
  logic [31:0] m0_awaddr, m0_araddr, m0_wdata;
  logic [2:0]  m0_awprot, m0_arprot;
  logic [3:0]  m0_wstrb;
  logic        m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid;
  logic [1:0]  m0_bresp, m0_rresp;
  logic [31:0] m0_rdata;

  logic        m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
  logic [31:0] m1_awaddr, m1_araddr, m1_wdata;
  logic [2:0]  m1_awprot, m1_arprot;
  logic [3:0]  m1_wstrb;
  logic        m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
  logic [1:0]  m1_bresp, m1_rresp;
  logic [31:0] m1_rdata;

  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr, s_araddr, s_wdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_aw_hs = 0, n_w_hs = 0, n_b1_hs = 0;

  axil_arb2 #(.ADDR_WIDTH(32)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready)
  );

  always #5 aclk = ~aclk;

  // slave-side handshake tally for the split-write case
  always @(posedge aclk) begin
    if (areset_n) begin
      if (s_awvalid && s_awready) n_aw_hs++;
      if (s_wvalid && s_wready)   n_w_hs++;
      if (m1_bvalid && m1_bready) n_b1_hs++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    step();
    step();
    areset_n = 1'b1;
  endtask

  // one read by master `who`, starting from IDLE one tick after an edge
  task automatic read_txn(input int unsigned who, input logic [31:0] data);
    logic [31:0] exp_addr;
    exp_addr = (who == 0) ? 32'h100 : 32'h200;
    step();
    s_arready = 1'b1;
    #1;
    check("rd_arvalid", 64'(s_arvalid), 64'(1));
    check("rd_araddr", 64'(s_araddr), 64'(exp_addr));
    check("rd_m0_arready", 64'(m0_arready), 64'(who == 0));
    check("rd_m1_arready", 64'(m1_arready), 64'(who == 1));
    step();
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = data;
    s_rresp   = 2'b00;
    #1;
    check("rd_arvalid_done", 64'(s_arvalid), 64'(0));
    check("rd_m0_rvalid", 64'(m0_rvalid), 64'(who == 0));
    check("rd_m1_rvalid", 64'(m1_rvalid), 64'(who == 1));
    check("rd_rdata", 64'((who == 0) ? m0_rdata : m1_rdata), 64'(data));
    step();
    s_rvalid = 1'b0;
    #1;
    check("rd_idle_rvalid", 64'(m0_rvalid | m1_rvalid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned aw0, w0, b0;
    areset_n = 1'b0;
    m0_awvalid = 0; m0_wvalid = 0; m0_arvalid = 0; m0_bready = 1; m0_rready = 1;
    m0_awaddr = '0; m0_araddr = 32'h100; m0_wdata = '0; m0_awprot = '0; m0_arprot = '0; m0_wstrb = '0;
    m1_awvalid = 0; m1_wvalid = 0; m1_arvalid = 0; m1_bready = 1; m1_rready = 1;
    m1_awaddr = '0; m1_araddr = 32'h200; m1_wdata = '0; m1_awprot = '0; m1_arprot = '0; m1_wstrb = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;

    // reset: requests and slave readies present, everything stays quiet
    m0_awvalid = 1; m0_wvalid = 1; s_awready = 1; s_wready = 1;
    step();
    check("rst_s_awvalid", 64'(s_awvalid), 64'(0));
    check("rst_m0_awready", 64'(m0_awready), 64'(0));
    check("rst_m0_wready", 64'(m0_wready), 64'(0));
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    step();
    areset_n = 1'b1;

    // single write from m0
    m0_awvalid = 1; m0_awaddr = 32'h10; m0_wvalid = 1; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
    #1;
    check("w1_idle_awvalid", 64'(s_awvalid), 64'(0));
    check("w1_idle_wvalid", 64'(s_wvalid), 64'(0));
    step();
    check("w1_awvalid", 64'(s_awvalid), 64'(1));
    check("w1_wvalid", 64'(s_wvalid), 64'(1));
    check("w1_awaddr", 64'(s_awaddr), 64'(32'h10));
    check("w1_wdata", 64'(s_wdata), 64'(32'hDEADBEEF));
    check("w1_wstrb", 64'(s_wstrb), 64'(4'hF));
    check("w1_m0_awready_wait", 64'(m0_awready), 64'(0));
    s_awready = 1; s_wready = 1;
    #1;
    check("w1_m0_awready", 64'(m0_awready), 64'(1));
    check("w1_m0_wready", 64'(m0_wready), 64'(1));
    check("w1_m1_awready", 64'(m1_awready), 64'(0));
    step();
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    #1;
    check("w1_m0_bvalid_pre", 64'(m0_bvalid), 64'(0));
    s_bvalid = 1; s_bresp = 2'b00;
    #1;
    check("w1_m0_bvalid", 64'(m0_bvalid), 64'(1));
    check("w1_m0_bresp", 64'(m0_bresp), 64'(2'b00));
    check("w1_s_bready", 64'(s_bready), 64'(1));
    check("w1_m1_bvalid", 64'(m1_bvalid), 64'(0));
    step();
    #1;
    check("w1_idle_s_bready", 64'(s_bready), 64'(0));
    check("w1_idle_m0_bvalid", 64'(m0_bvalid), 64'(0));
    s_bvalid = 0;

    // contention and fairness: both read continuously, grants alternate from m0
    do_reset();
    m0_arvalid = 1; m1_arvalid = 1;
    for (int unsigned i = 0; i < 8; i++)
      read_txn(i % 2, 32'hA000_0000 + i);
    m0_arvalid = 0; m1_arvalid = 0;
    step();

    // split write from m1: W early, AW ready delayed
    aw0 = n_aw_hs; w0 = n_w_hs; b0 = n_b1_hs;
    m1_wvalid = 1; m1_wdata = 32'hCAFE0001; m1_wstrb = 4'h3;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("sw_early_wvalid", 64'(s_wvalid), 64'(0));
      step();
    end
    m1_awvalid = 1; m1_awaddr = 32'h20; s_wready = 1;
    step();
    check("sw_awvalid", 64'(s_awvalid), 64'(1));
    check("sw_wvalid", 64'(s_wvalid), 64'(1));
    check("sw_m1_wready", 64'(m1_wready), 64'(1));
    check("sw_m1_awready", 64'(m1_awready), 64'(0));
    check("sw_awaddr", 64'(s_awaddr), 64'(32'h20));
    step();
    check("sw_wvalid_done", 64'(s_wvalid), 64'(0));
    check("sw_m1_wready_done", 64'(m1_wready), 64'(0));
    check("sw_b_early", 64'(m1_bvalid | s_bready), 64'(0));
    step();
    s_awready = 1;
    #1;
    check("sw_m1_awready", 64'(m1_awready), 64'(1));
    step();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b01;
    #1;
    check("sw_m1_bvalid", 64'(m1_bvalid), 64'(1));
    check("sw_m1_bresp", 64'(m1_bresp), 64'(2'b01));
    check("sw_m0_bvalid", 64'(m0_bvalid), 64'(0));
    step();
    s_bvalid = 0;
    step();
    check("sw_aw_count", 64'(n_aw_hs - aw0), 64'(1));
    check("sw_w_count", 64'(n_w_hs - w0), 64'(1));
    check("sw_b_count", 64'(n_b1_hs - b0), 64'(1));

    // mixed: m0 write and read together, write first
    m0_awvalid = 1; m0_awaddr = 32'h30; m0_wvalid = 1; m0_arvalid = 1; m0_araddr = 32'h40;
    step();
    check("mx_awvalid", 64'(s_awvalid), 64'(1));
    check("mx_arvalid", 64'(s_arvalid), 64'(0));
    s_awready = 1; s_wready = 1;
    step();
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b00;
    step();
    s_bvalid = 0;
    #1;
    check("mx_idle_arvalid", 64'(s_arvalid), 64'(0));
    step();
    check("mx_rd_arvalid", 64'(s_arvalid), 64'(1));
    check("mx_rd_araddr", 64'(s_araddr), 64'(32'h40));
    s_arready = 1;
    step();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h12345678; s_rresp = 2'b10;
    #1;
    check("mx_m0_rvalid", 64'(m0_rvalid), 64'(1));
    check("mx_m0_rdata", 64'(m0_rdata), 64'(32'h12345678));
    check("mx_m0_rresp", 64'(m0_rresp), 64'(2'b10));
    step();
    s_rvalid = 0; s_rresp = 2'b00;

    // reset mid-write after AW accepted
    m0_awvalid = 1; m0_awaddr = 32'h50; m0_wvalid = 1;
    step();
    s_awready = 1;
    step();
    s_awready = 0;
    #1;
    check("rw_aw_done", 64'(s_awvalid), 64'(0));
    check("rw_wvalid_pre", 64'(s_wvalid), 64'(1));
    areset_n = 1'b0;
    s_wready = 1; s_bvalid = 1;
    #1;
    check("rw_rst_valids", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 64'(0));
    check("rw_rst_m0_rdy", 64'({m0_awready, m0_wready, m0_bvalid}), 64'(0));
    s_wready = 0; s_bvalid = 0;
    step();
    areset_n = 1'b1;
    #1;
    check("rw_idle_awvalid", 64'(s_awvalid), 64'(0));
    step();
    check("rw_re_awvalid", 64'(s_awvalid), 64'(1));
    check("rw_re_awaddr", 64'(s_awaddr), 64'(32'h50));
    s_awready = 1; s_wready = 1;
    step();
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b00;
    #1;
    check("rw_re_bvalid", 64'(m0_bvalid), 64'(1));
    step();
    s_bvalid = 0;
    #1;
    check("rw_end_idle", 64'(s_bready | m0_bvalid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
